// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR output constants, sample typedefs and the saturation helper
package fir_pkg;

    localparam int FIR_IN_W  = 22;
    localparam int FIR_OUT_W = 16;

    typedef logic signed [FIR_IN_W-1:0]  fir_in_t;
    typedef logic signed [FIR_OUT_W-1:0] fir_out_t;

    function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

endpackage

// File: rtl/fir_decim_out_buffer_if.sv
// fir_decim_out_buffer_if: filter-result input, drained output stream and status of the decimating buffer
interface fir_decim_out_buffer_if import fir_pkg::*; #(
    parameter int IN_W  = FIR_IN_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic signed [IN_W-1:0]  fir_data;
    logic                    fir_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [LW-1:0]           fill_level;
    logic                    overflow;
    logic                    clear_overflow;

    modport master (
        output fir_data, fir_valid, out_ready, clear_overflow,
        input  out_data, out_valid, fill_level, overflow
    );

    modport slave (
        input  fir_data, fir_valid, out_ready, clear_overflow,
        output out_data, out_valid, fill_level, overflow
    );

endinterface

// File: rtl/fir_out_fifo.sv
// fir_out_fifo: show-ahead FIFO with a registered head word that holds its last value when empty
module fir_out_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [AW:0]  rptr_n;
    logic         do_push;
    logic         do_pop;

    assign empty   = wptr == rptr;
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rptr_n  = rptr + (AW+1)'(do_pop);

    // storage array; contents are only observed through the registered head
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

    // pointers, occupancy and head word; a push into an empty slot bypasses straight to the head
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            dout  <= '0;
        end else begin
            wptr  <= wptr + (AW+1)'(do_push);
            rptr  <= rptr_n;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (do_push && rptr_n == wptr) dout <= din;
            else if (rptr_n != wptr) dout <= mem[rptr_n[AW-1:0]];
        end
    end

endmodule

// File: rtl/fir_decim_out_buffer.sv
// fir_decim_out_buffer: decimate, rescale and saturate FIR results, then buffer them for a valid/ready consumer
// FIR_OUT_ROUND_EN selects round-half-up before the shift; otherwise the shift truncates toward minus infinity.
module fir_decim_out_buffer import fir_pkg::*; #(
    parameter int IN_W  = FIR_IN_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int SHIFT = 6,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    fir_decim_out_buffer_if.slave    bus
);

    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [CW-1:0]      cnt;
    logic               keep;
    logic signed [31:0] wide;
    logic signed [31:0] scaled;
    logic               s_valid;
    logic [OUT_W-1:0]   s_data;
    logic               full;
    logic               empty;

    assign keep = bus.fir_valid && cnt == '0;
    assign wide = 32'(bus.fir_data);

`ifdef FIR_OUT_ROUND_EN
    assign scaled = (wide + (32'sd1 <<< (SHIFT - 1))) >>> SHIFT;
`else
    assign scaled = wide >>> SHIFT;
`endif

    assign bus.out_valid = !empty;

    // decimation phase: the sample arriving at phase 0 is kept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (bus.fir_valid) cnt <= (cnt == CW'(DECIM - 1)) ? '0 : cnt + 1'b1;
    end

    // scaler register feeding the FIFO push one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_valid <= 1'b0;
            s_data  <= '0;
        end else begin
            s_valid <= keep;
            if (keep) s_data <= OUT_W'(saturate(scaled, OUT_W));
        end
    end

    // sticky drop flag; a new drop outranks a clear in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.overflow <= 1'b0;
        else if (s_valid && full && !(bus.out_ready && !empty)) bus.overflow <= 1'b1;
        else if (bus.clear_overflow) bus.overflow <= 1'b0;
    end

    fir_out_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s_valid),
        .din   (s_data),
        .pop   (bus.out_ready),
        .dout  (bus.out_data),
        .full  (full),
        .empty (empty),
        .level (bus.fill_level)
    );

endmodule

// File: tb/tb_fir_decim_out_buffer.sv
// tb_fir_decim_out_buffer: table vectors plus scoreboarded streams on a DECIM=4 and a DECIM=1 instance
module tb_fir_decim_out_buffer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fir_decim_out_buffer_if #(.DEPTH(8)) bus4 ();
    fir_decim_out_buffer_if #(.DEPTH(8)) bus1 ();

    fir_decim_out_buffer #(.DECIM(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    fir_decim_out_buffer #(.DECIM(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct {
        int din;
        int exp_floor;
        int exp_round;
    } vec_t;

    vec_t tbl [10];
    int   n_vec = 0;
    int   n_err = 0;
    int   c4 = 0;
    int   q4 [$];
    int   q1 [$];

    function automatic int model(int d);
        int v;
        v = d;
`ifdef FIR_OUT_ROUND_EN
        v = v + 32;
`endif
        v = v >>> 6;
        return (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus4.out_valid && bus4.out_ready) begin
            if (q4.size() == 0) chk("dut4 unexpected output", int'(bus4.out_data), -99999);
            else chk("dut4 out_data", int'(bus4.out_data), q4.pop_front());
        end
        if (bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) chk("dut1 unexpected output", int'(bus1.out_data), -99999);
            else chk("dut1 out_data", int'(bus1.out_data), q1.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(int d, bit push1, int exp1);
        bus4.fir_data  = 22'(d);
        bus1.fir_data  = 22'(d);
        bus4.fir_valid = 1'b1;
        bus1.fir_valid = 1'b1;
        if (c4 == 0) q4.push_back(model(d));
        c4 = (c4 + 1) % 4;
        if (push1) q1.push_back(exp1);
        tick();
        bus4.fir_valid = 1'b0;
        bus1.fir_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{64, 1, 1};
        tbl[1] = '{2097151, 32767, 32767};
        tbl[2] = '{-2097152, -32768, -32768};
        tbl[3] = '{-64, -1, -1};
        tbl[4] = '{96, 1, 2};
        tbl[5] = '{-96, -2, -1};
        tbl[6] = '{0, 0, 0};
        tbl[7] = '{63, 0, 1};
        tbl[8] = '{-1, -1, 0};
        tbl[9] = '{-65, -2, -1};

        reset = 1'b1;
        bus4.fir_data = '0; bus4.fir_valid = 1'b0; bus4.out_ready = 1'b1; bus4.clear_overflow = 1'b0;
        bus1.fir_data = '0; bus1.fir_valid = 1'b0; bus1.out_ready = 1'b1; bus1.clear_overflow = 1'b0;
        #12;
        chk("reset out_valid", int'(bus1.out_valid), 0);
        chk("reset fill_level", int'(bus1.fill_level), 0);
        chk("reset overflow", int'(bus1.overflow), 0);
        chk("reset out_data", int'(bus4.out_data), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        send(64, 1'b1, 1);
        chk("latency out_valid after 1 cycle", int'(bus4.out_valid), 0);
        tick();
        chk("latency out_valid after 2 cycles", int'(bus4.out_valid), 1);
        for (int i = 2; i <= 16; i++) send(64 * i, 1'b1, i);
        repeat (6) tick();
        chk("decim stream drained", q4.size(), 0);
        chk("empty holds last out_data", int'(bus4.out_data), 13);
        chk("empty out_valid", int'(bus4.out_valid), 0);

        for (int i = 0; i < 10; i++) begin
`ifdef FIR_OUT_ROUND_EN
            send(tbl[i].din, 1'b1, tbl[i].exp_round);
`else
            send(tbl[i].din, 1'b1, tbl[i].exp_floor);
`endif
        end
        repeat (6) tick();
        chk("table drained", q1.size(), 0);

        bus1.out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) send((100 + k) * 64, 1'b1, 100 + k);
        repeat (2) tick();
        chk("full fill_level", int'(bus1.fill_level), 8);
        chk("full no overflow", int'(bus1.overflow), 0);
        send(109 * 64, 1'b0, 0);
        bus1.clear_overflow = 1'b1;
        tick();
        bus1.clear_overflow = 1'b0;
        chk("overflow set wins over clear", int'(bus1.overflow), 1);
        chk("overflow fill_level stays", int'(bus1.fill_level), 8);
        bus1.clear_overflow = 1'b1;
        tick();
        bus1.clear_overflow = 1'b0;
        chk("overflow cleared", int'(bus1.overflow), 0);
        send(110 * 64, 1'b1, 110);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        chk("full push+pop fill_level", int'(bus1.fill_level), 8);
        chk("full push+pop no overflow", int'(bus1.overflow), 0);
        bus1.out_ready = 1'b1;
        repeat (12) tick();
        chk("overflow drain complete", q1.size(), 0);
        chk("drained fill_level", int'(bus1.fill_level), 0);
        chk("drained last out_data", int'(bus1.out_data), 110);

        bus1.out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) send((200 + k) * 64, 1'b1, 200 + k);
        chk("pre-reset fill_level", int'(bus1.fill_level), 5);
        reset = 1'b1;
        #1;
        chk("async reset out_valid", int'(bus1.out_valid), 0);
        chk("async reset fill_level", int'(bus1.fill_level), 0);
        q1.delete();
        q4.delete();
        c4 = 0;
        bus1.out_ready = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        send(300 * 64, 1'b1, 300);
        chk("post-reset out_valid after 1 cycle", int'(bus4.out_valid), 0);
        tick();
        chk("post-reset first sample kept", int'(bus4.out_valid), 1);
        chk("post-reset out_data", int'(bus4.out_data), 300);
        repeat (4) tick();
        chk("final dut4 queue", q4.size(), 0);
        chk("final dut1 queue", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
